// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the EX-stage operand inputs coming from the ID/EX slot
// and the EX/MEM pipeline register outputs going to the memory stage.
//   Instr    : instruction currently in EX
//   RD1/RD2  : rs / rt register values
//   PCplus4  : address of the instruction + 4
//   *_M      : registered EX/MEM fields (controls, ALU result, store data,
//              destination register, branch target)
// master = the surrounding pipeline (drives operands, consumes EX/MEM fields)
// slave  = the execute stage itself
interface ex_stage_if;
  logic [31:0] Instr;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] PCplus4;

  logic        RegWrite_M;
  logic        MemtoReg_M;
  logic        MemWrite_M;
  logic        Branch_M;
  logic        zero_M;
  logic [31:0] ALUOut_M;
  logic [31:0] WriteData_M;
  logic [4:0]  WriteReg_M;
  logic [31:0] PCBranch_M;

  modport master (
    output Instr, RD1, RD2, PCplus4,
    input  RegWrite_M, MemtoReg_M, MemWrite_M, Branch_M, zero_M,
           ALUOut_M, WriteData_M, WriteReg_M, PCBranch_M
  );

  modport slave (
    input  Instr, RD1, RD2, PCplus4,
    output RegWrite_M, MemtoReg_M, MemWrite_M, Branch_M, zero_M,
           ALUOut_M, WriteData_M, WriteReg_M, PCBranch_M
  );
endinterface

// File: rtl/ex_stage_unit.sv
// ex_stage_unit: execute stage of a 5-stage MIPS-subset pipeline.
// Decodes the instruction in EX, selects ALU operands, computes the ALU
// result, branch condition, branch target and destination register, and
// captures everything in the EX/MEM register (one cycle latency).
//   CLK   : pipeline clock, rising edge
//   RESET : asynchronous active-low clear of the EX/MEM register
//   FLUSH : synchronous; control bits are captured as a bubble (data fields
//           are still loaded)
//   bus   : operand inputs and EX/MEM outputs (see ex_stage_if)
module ex_stage_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  ex_stage_if.slave   bus
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9
  } alu_op_t;

  // Instruction fields
  logic [5:0]  op_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;

  assign op_s    = bus.Instr[31:26];
  assign rt_s    = bus.Instr[20:16];
  assign rd_s    = bus.Instr[15:11];
  assign shamt_s = bus.Instr[10:6];
  assign funct_s = bus.Instr[5:0];
  assign imm_s   = bus.Instr[15:0];

  // The rs index is resolved upstream; its value arrives on RD1.
  logic unused_rs_s;
  assign unused_rs_s = ^bus.Instr[25:21];

  // Decoded controls
  logic    reg_write_s;
  logic    mem_to_reg_s;
  logic    mem_write_s;
  logic    branch_s;
  logic    bne_s;
  logic    alu_src_s;
  logic    reg_dst_s;
  logic    shamt_src_s;
  logic    imm_zext_s;
  alu_op_t alu_op_s;

  // Datapath
  logic [31:0] src_a_s;
  logic [31:0] src_b_s;
  logic [31:0] imm_ext_s;
  logic [31:0] alu_result_s;
  logic        zero_s;
  logic [4:0]  write_reg_s;
  logic [31:0] pc_branch_s;

  // EX/MEM register
  logic        reg_write_r;
  logic        mem_to_reg_r;
  logic        mem_write_r;
  logic        branch_r;
  logic        zero_r;
  logic [31:0] alu_out_r;
  logic [31:0] write_data_r;
  logic [4:0]  write_reg_r;
  logic [31:0] pc_branch_r;

  // Instruction decode; anything unrecognised leaves every control at 0
  // and falls back to a plain RD1+RD2 add so ALUOut stays deterministic.
  always_comb begin
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    mem_write_s  = 1'b0;
    branch_s     = 1'b0;
    bne_s        = 1'b0;
    alu_src_s    = 1'b0;
    reg_dst_s    = 1'b0;
    shamt_src_s  = 1'b0;
    imm_zext_s   = 1'b0;
    alu_op_s     = ALU_ADD;
    case (op_s)
      6'h00: begin
        // Tentatively mark as a valid R-type; cleared again for unknown funct.
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        case (funct_s)
          6'h20, 6'h21: alu_op_s = ALU_ADD;
          6'h22, 6'h23: alu_op_s = ALU_SUB;
          6'h24:        alu_op_s = ALU_AND;
          6'h25:        alu_op_s = ALU_OR;
          6'h26:        alu_op_s = ALU_XOR;
          6'h27:        alu_op_s = ALU_NOR;
          6'h2A:        alu_op_s = ALU_SLT;
          6'h00: begin alu_op_s = ALU_SLL; shamt_src_s = 1'b1; end
          6'h02: begin alu_op_s = ALU_SRL; shamt_src_s = 1'b1; end
          6'h03: begin alu_op_s = ALU_SRA; shamt_src_s = 1'b1; end
          6'h04:        alu_op_s = ALU_SLL;
          6'h06:        alu_op_s = ALU_SRL;
          6'h07:        alu_op_s = ALU_SRA;
          default: begin
            reg_write_s = 1'b0;
            reg_dst_s   = 1'b0;
            alu_op_s    = ALU_ADD;
          end
        endcase
      end
      6'h08, 6'h09: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        alu_op_s    = ALU_ADD;
      end
      6'h0C: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        imm_zext_s  = 1'b1;
        alu_op_s    = ALU_AND;
      end
      6'h0D: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        imm_zext_s  = 1'b1;
        alu_op_s    = ALU_OR;
      end
      6'h0E: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        imm_zext_s  = 1'b1;
        alu_op_s    = ALU_XOR;
      end
      6'h23: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        alu_src_s    = 1'b1;
        alu_op_s     = ALU_ADD;
      end
      6'h2B: begin
        mem_write_s = 1'b1;
        alu_src_s   = 1'b1;
        alu_op_s    = ALU_ADD;
      end
      6'h04: begin
        branch_s = 1'b1;
        alu_op_s = ALU_SUB;
      end
      6'h05: begin
        branch_s = 1'b1;
        bne_s    = 1'b1;
        alu_op_s = ALU_SUB;
      end
      default: begin
        alu_op_s = ALU_ADD;
      end
    endcase
  end

  // Operand selection: A is rs or the shamt field, B is rt or the extended immediate.
  always_comb begin
    imm_ext_s = imm_zext_s ? {16'd0, imm_s} : {{16{imm_s[15]}}, imm_s};
    src_a_s   = shamt_src_s ? {27'd0, shamt_s} : bus.RD1;
    src_b_s   = alu_src_s ? imm_ext_s : bus.RD2;
  end

  // ALU; shifts move B by the low 5 bits of A.
  always_comb begin
    alu_result_s = 32'd0;
    case (alu_op_s)
      ALU_ADD: alu_result_s = src_a_s + src_b_s;
      ALU_SUB: alu_result_s = src_a_s - src_b_s;
      ALU_AND: alu_result_s = src_a_s & src_b_s;
      ALU_OR:  alu_result_s = src_a_s | src_b_s;
      ALU_XOR: alu_result_s = src_a_s ^ src_b_s;
      ALU_NOR: alu_result_s = ~(src_a_s | src_b_s);
      ALU_SLT: alu_result_s = {31'd0, ($signed(src_a_s) < $signed(src_b_s))};
      ALU_SLL: alu_result_s = src_b_s << src_a_s[4:0];
      ALU_SRL: alu_result_s = src_b_s >> src_a_s[4:0];
      ALU_SRA: alu_result_s = $unsigned($signed(src_b_s) >>> src_a_s[4:0]);
      default: alu_result_s = src_a_s + src_b_s;
    endcase
  end

  // Branch condition (inverted for bne), destination register and branch target.
  always_comb begin
    if (bne_s) begin
      zero_s = (alu_result_s != 32'd0);
    end else begin
      zero_s = (alu_result_s == 32'd0);
    end
    write_reg_s = reg_dst_s ? rd_s : rt_s;
    pc_branch_s = bus.PCplus4 + {{14{imm_s[15]}}, imm_s, 2'b00};
  end

  // EX/MEM pipeline register; FLUSH zeroes only the control bits.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mem_write_r  <= 1'b0;
      branch_r     <= 1'b0;
      zero_r       <= 1'b0;
      alu_out_r    <= 32'd0;
      write_data_r <= 32'd0;
      write_reg_r  <= 5'd0;
      pc_branch_r  <= 32'd0;
    end else begin
      alu_out_r    <= alu_result_s;
      write_data_r <= bus.RD2;
      write_reg_r  <= write_reg_s;
      pc_branch_r  <= pc_branch_s;
      if (FLUSH) begin
        reg_write_r  <= 1'b0;
        mem_to_reg_r <= 1'b0;
        mem_write_r  <= 1'b0;
        branch_r     <= 1'b0;
        zero_r       <= 1'b0;
      end else begin
        reg_write_r  <= reg_write_s;
        mem_to_reg_r <= mem_to_reg_s;
        mem_write_r  <= mem_write_s;
        branch_r     <= branch_s;
        zero_r       <= zero_s;
      end
    end
  end

  assign bus.RegWrite_M  = reg_write_r;
  assign bus.MemtoReg_M  = mem_to_reg_r;
  assign bus.MemWrite_M  = mem_write_r;
  assign bus.Branch_M    = branch_r;
  assign bus.zero_M      = zero_r;
  assign bus.ALUOut_M    = alu_out_r;
  assign bus.WriteData_M = write_data_r;
  assign bus.WriteReg_M  = write_reg_r;
  assign bus.PCBranch_M  = pc_branch_r;

endmodule

// File: tb/tb_ex_stage_unit.sv
// tb_ex_stage_unit: directed and randomized checks of ex_stage_unit against
// an instruction-level reference model.
module tb_ex_stage_unit;
  logic CLK = 1'b0;
  logic RESET;
  logic FLUSH;

  ex_stage_if bus ();

  ex_stage_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .FLUSH (FLUSH),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  localparam logic [5:0] R_FN [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                       6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03,
                                       6'h04, 6'h06, 6'h07, 6'h3F};
  localparam logic [5:0] I_OP [11] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                                       6'h2B, 6'h04, 6'h05, 6'h3F, 6'h02};

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference: what the EX/MEM register must hold after an edge with these inputs.
  // Packed as {RegWrite, MemtoReg, MemWrite, Branch, zero, ALUOut, WriteData, WriteReg, PCBranch}.
  function automatic logic [105:0] model(input logic [31:0] ins, a, b, pc4, input logic fl);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] sx;
    logic [31:0] zx;
    logic [31:0] res;
    logic        rw, m2r, mw, br, z, is_bne;
    logic [4:0]  dst;
    op = ins[31:26];
    fn = ins[5:0];
    sh = ins[10:6];
    sx = 32'(signed'(ins[15:0]));
    zx = {16'd0, ins[15:0]};
    res = a + b;
    rw = 1'b0; m2r = 1'b0; mw = 1'b0; br = 1'b0; is_bne = 1'b0;
    dst = ins[20:16];
    if (op == 6'h00) begin
      rw  = 1'b1;
      dst = ins[15:11];
      case (fn)
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: res = $unsigned($signed(b) >>> sh);
        6'h04: res = b << a[4:0];
        6'h06: res = b >> a[4:0];
        6'h07: res = $unsigned($signed(b) >>> a[4:0]);
        default: begin rw = 1'b0; dst = ins[20:16]; res = a + b; end
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin res = a + sx; rw = 1'b1; end
        6'h0C: begin res = a & zx; rw = 1'b1; end
        6'h0D: begin res = a | zx; rw = 1'b1; end
        6'h0E: begin res = a ^ zx; rw = 1'b1; end
        6'h23: begin res = a + sx; rw = 1'b1; m2r = 1'b1; end
        6'h2B: begin res = a + sx; mw = 1'b1; end
        6'h04: begin res = a - b; br = 1'b1; end
        6'h05: begin res = a - b; br = 1'b1; is_bne = 1'b1; end
        default: res = a + b;
      endcase
    end
    z = is_bne ? (res != 32'd0) : (res == 32'd0);
    if (fl) begin
      rw = 1'b0; m2r = 1'b0; mw = 1'b0; br = 1'b0; z = 1'b0;
    end
    return {rw, m2r, mw, br, z, res, b, dst, pc4 + (sx << 2)};
  endfunction

  function automatic logic [105:0] dut_vec();
    return {bus.RegWrite_M, bus.MemtoReg_M, bus.MemWrite_M, bus.Branch_M, bus.zero_M,
            bus.ALUOut_M, bus.WriteData_M, bus.WriteReg_M, bus.PCBranch_M};
  endfunction

  // Per-cycle comparison of the whole EX/MEM register against the model.
  logic [105:0] exp_v;
  logic [105:0] got_v;
  always @(posedge CLK) begin
    if (chk_en && RESET) begin
      exp_v = model(bus.Instr, bus.RD1, bus.RD2, bus.PCplus4, FLUSH);
      #1;
      got_v = dut_vec();
      total_cnt++;
      if (got_v === exp_v) begin
        pass_cnt++;
      end else begin
        $display("FAIL cycle_model t=%0t instr=%h: got %h expected %h",
                 $time, bus.Instr, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction after a falling edge and return shortly after the
  // rising edge that captures it.
  task automatic apply(input logic [31:0] ins, a, b, pc4, input logic fl);
    @(negedge CLK);
    bus.Instr   = ins;
    bus.RD1     = a;
    bus.RD2     = b;
    bus.PCplus4 = pc4;
    FLUSH       = fl;
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {27'd0, bus.RegWrite_M, bus.MemtoReg_M, bus.MemWrite_M,
                         bus.Branch_M, bus.zero_M}, 32'd0);
    chk({tag, "_aluout"}, bus.ALUOut_M, 32'd0);
    chk({tag, "_wdata"}, bus.WriteData_M, 32'd0);
    chk({tag, "_wreg"}, {27'd0, bus.WriteReg_M}, 32'd0);
    chk({tag, "_pcbr"}, bus.PCBranch_M, 32'd0);
  endtask

  initial begin
    logic [31:0] ins, a, b;
    RESET = 1'b0;
    FLUSH = 1'b0;
    bus.Instr = 32'd0; bus.RD1 = 32'd0; bus.RD2 = 32'd0; bus.PCplus4 = 32'd0;
    #3;
    chk_all_zero("reset_init");
    @(negedge CLK);
    RESET = 1'b1;
    chk_en = 1'b1;

    // add $3,$1,$2
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 32'h0000_0040, 1'b0);
    chk("add_aluout", bus.ALUOut_M, 32'd12);
    chk("add_wreg", {27'd0, bus.WriteReg_M}, 32'd3);

    // Asynchronous reset in the middle of a cycle with nonzero outputs
    RESET = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    @(negedge CLK);
    RESET = 1'b1;
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 32'h0000_0040, 1'b0);
    chk("add2_aluout", bus.ALUOut_M, 32'd12);
    chk("add2_wreg", {27'd0, bus.WriteReg_M}, 32'd3);
    chk("add2_regwrite", {31'd0, bus.RegWrite_M}, 32'd1);
    chk("add2_zero", {31'd0, bus.zero_M}, 32'd0);

    // R-type sweep
    apply(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 32'hFFFF_FFF0, 32'h0000_000F, 32'd0, 1'b0);
    chk("sub", bus.ALUOut_M, 32'hFFFF_FFE1);
    chk("sub_wreg", {27'd0, bus.WriteReg_M}, 32'd4);
    apply(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h27), 32'hFFFF_FFF0, 32'h0000_000F, 32'd0, 1'b0);
    chk("nor", bus.ALUOut_M, 32'h0000_0000);
    apply(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h2A), 32'hFFFF_FFF0, 32'h0000_000F, 32'd0, 1'b0);
    chk("slt", bus.ALUOut_M, 32'd1);
    apply(rtype(5'd0, 5'd2, 5'd5, 5'd4, 6'h03), 32'hFFFF_FFF0, 32'h8000_0000, 32'd0, 1'b0);
    chk("sra", bus.ALUOut_M, 32'hF800_0000);
    apply(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h06), 32'd36, 32'h8000_0000, 32'd0, 1'b0);
    chk("srlv", bus.ALUOut_M, 32'h0800_0000);

    // Immediates
    apply(itype(6'h0D, 5'd1, 5'd7, 16'h8000), 32'd1, 32'h1234_5678, 32'd0, 1'b0);
    chk("ori", bus.ALUOut_M, 32'h0000_8001);
    chk("ori_wreg", {27'd0, bus.WriteReg_M}, 32'd7);
    apply(itype(6'h08, 5'd1, 5'd8, 16'h8000), 32'd1, 32'h1234_5678, 32'd0, 1'b0);
    chk("addi", bus.ALUOut_M, 32'hFFFF_8001);
    chk("addi_wreg", {27'd0, bus.WriteReg_M}, 32'd8);
    apply(itype(6'h0E, 5'd1, 5'd10, 16'hFFFF), 32'd1, 32'h1234_5678, 32'd0, 1'b0);
    chk("xori", bus.ALUOut_M, 32'h0000_FFFE);
    chk("xori_wreg", {27'd0, bus.WriteReg_M}, 32'd10);

    // Memory
    apply(itype(6'h23, 5'd1, 5'd9, 16'h0008), 32'h100, 32'd0, 32'd0, 1'b0);
    chk("lw_addr", bus.ALUOut_M, 32'h108);
    chk("lw_memtoreg", {31'd0, bus.MemtoReg_M}, 32'd1);
    chk("lw_regwrite", {31'd0, bus.RegWrite_M}, 32'd1);
    chk("lw_wreg", {27'd0, bus.WriteReg_M}, 32'd9);
    apply(itype(6'h2B, 5'd1, 5'd9, 16'h0008), 32'h100, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("sw_memwrite", {31'd0, bus.MemWrite_M}, 32'd1);
    chk("sw_regwrite", {31'd0, bus.RegWrite_M}, 32'd0);
    chk("sw_wdata", bus.WriteData_M, 32'hDEAD_BEEF);

    // Branches
    apply(itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'd3, 32'd3, 32'h20, 1'b0);
    chk("beq_branch", {31'd0, bus.Branch_M}, 32'd1);
    chk("beq_zero", {31'd0, bus.zero_M}, 32'd1);
    chk("beq_target", bus.PCBranch_M, 32'h18);
    apply(itype(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'd3, 32'd3, 32'h20, 1'b0);
    chk("bne_eq_zero", {31'd0, bus.zero_M}, 32'd0);
    chk("bne_eq_branch", {31'd0, bus.Branch_M}, 32'd1);
    apply(itype(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'd3, 32'd4, 32'h20, 1'b0);
    chk("bne_ne_zero", {31'd0, bus.zero_M}, 32'd1);

    // Bubbles
    apply(32'hFFFF_FFFF, 32'd3, 32'd4, 32'h20, 1'b0);
    chk("halt_ctrl", {28'd0, bus.RegWrite_M, bus.MemtoReg_M, bus.MemWrite_M, bus.Branch_M},
        32'd0);
    apply(itype(6'h2B, 5'd1, 5'd9, 16'h0008), 32'h100, 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("flush_memwrite", {31'd0, bus.MemWrite_M}, 32'd0);
    chk("flush_branch", {31'd0, bus.Branch_M}, 32'd0);
    chk("flush_aluout", bus.ALUOut_M, 32'h108);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                                R_FN[$urandom_range(0, 15)]);
        4, 5, 6:    ins = itype(I_OP[$urandom_range(0, 10)], 5'($urandom), 5'($urandom),
                                16'($urandom));
        7:          ins = $urandom;
        8:          ins = 32'hFFFF_FFFF;
        default: begin
          ins = itype(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, 5'($urandom),
                      5'($urandom), 16'($urandom));
          b = a;
        end
      endcase
      apply(ins, a, b, $urandom, ($urandom_range(0, 9) == 0));
    end

    @(negedge CLK);
    chk_en = 1'b0;
    #20;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_stage_unit.md
Name: ex_stage_unit

Overview:
- Execute stage of the 5-stage MIPS-subset pipeline.
- Combinationally decodes the instruction held in the ID/EX slot into control signals.
- Selects ALU operands, computes the ALU result, branch condition, branch target and destination register.
- Registers all of these into the EX/MEM pipeline register, feeding data memory and the PC-select mux.

Parameters:
- none (32-bit datapath, 5-bit register indices fixed)

Ports:
- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  asynchronous, active-low; clears EX/MEM register
- FLUSH  in  1  synchronous; captures a bubble instead of the current instruction
- Instr  in  32  instruction in EX (op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0])
- RD1  in  32  rs register value
- RD2  in  32  rt register value
- PCplus4  in  32  address of instruction + 4
- RegWrite_M  out  1  registered write-back enable
- MemtoReg_M  out  1  registered; write-back selects memory data
- MemWrite_M  out  1  registered data-memory write enable
- Branch_M  out  1  registered; instruction is beq/bne
- zero_M  out  1  registered branch condition
- ALUOut_M  out  32  registered ALU result / memory address
- WriteData_M  out  32  registered RD2 (store data)
- WriteReg_M  out  5  registered destination register
- PCBranch_M  out  32  registered branch target

Behaviour:
- Reset: while RESET=0, every output is 0 (asynchronous). Registers update only on CLK rise with RESET=1.
- Latency: one cycle. Values present before edge k appear on outputs after edge k and hold until edge k+1.
- FLUSH=1 at an edge:
  - RegWrite_M, MemtoReg_M, MemWrite_M, Branch_M, zero_M are loaded with 0.
  - Data fields are loaded normally.
- Decode, R-type (op=0x00), by funct. All have RegWrite=1 and RegDst=1 (dest rd).
  - add 0x20 and addu 0x21: A+B.
  - sub 0x22 and subu 0x23: A-B.
  - and 0x24, or 0x25, xor 0x26.
  - nor 0x27: ~(A|B).
  - slt 0x2A: signed A<B gives 1, else 0.
  - sll 0x00, srl 0x02, sra 0x03: A=shamt; result is B shifted by A[4:0].
  - sllv 0x04, srlv 0x06, srav 0x07: result is rt value shifted by rs[4:0].
- Decode, I-type. RegDst=0 (dest rt), ALUSrc=1 (B = immediate).
  - addi 0x08 and addiu 0x09: sign-extended imm, add.
  - andi 0x0C, ori 0x0D, xori 0x0E: immediate zero-extended.
  - lw 0x23: add, MemtoReg=1, RegWrite=1.
  - sw 0x2B: add, MemWrite=1, RegWrite=0.
- Decode, branches.
  - beq 0x04 and bne 0x05: B=RD2, subtract, Branch=1, RegWrite=0.
  - beq: zero = (result==0).
  - bne: zero = (result!=0).
- Decode, everything else: all controls 0, including unknown op/funct and the halt word 0xFFFFFFFF. ALUOut is then don't-care but deterministic: A+B.
- zero for non-branches = (ALU result==0). It is unused by consumers unless Branch_M=1.
- Arithmetic:
  - No overflow traps; add/sub wrap modulo 2^32.
  - sra/srav replicate bit 31.
  - Shift amounts use only the low 5 bits.
- PCBranch_M = PCplus4 + (signext(imm) << 2), modulo 2^32, computed for every instruction.
- WriteData_M = RD2 unmodified. WriteReg_M = rd if RegDst, else rt.

Test Plan:
- Reset: RESET=0 mid-cycle with nonzero outputs -> all outputs 0 immediately; RESET=1 and next edge with add $3,$1,$2 (RD1=5, RD2=7) -> ALUOut_M=12, WriteReg_M=3, RegWrite_M=1, zero_M=0.
- R-type sweep: RD1=0xFFFFFFF0, RD2=0x0000000F:
  - sub -> 0xFFFFFFE1
  - nor -> 0x00000000
  - slt -> 1
  - sra $d,rt,4 with RD2=0x80000000 -> 0xF8000000
  - srlv with RD1=36 (shift 4) -> 0x08000000
- Immediates: RD1=0x00000001:
  - ori imm 0x8000 -> 0x00008001
  - addi imm 0x8000 -> 0xFFFF8001
  - xori imm 0xFFFF -> 0x0000FFFE
  - WriteReg_M=rt in every case
- Memory: lw rt=9, RD1=0x100, imm=8 -> ALUOut_M=0x108, MemtoReg_M=1, RegWrite_M=1; sw with RD2=0xDEADBEEF -> MemWrite_M=1, RegWrite_M=0, WriteData_M=0xDEADBEEF.
- Branches: PCplus4=0x20, imm=0xFFFE.
  - beq, RD1=RD2=3 -> Branch_M=1, zero_M=1, PCBranch_M=0x18.
  - bne same operands -> zero_M=0.
  - bne, RD1=3, RD2=4 -> zero_M=1.
- Bubbles: Instr=0xFFFFFFFF -> all control outputs 0; FLUSH=1 with sw -> MemWrite_M=0 and Branch_M=0, while ALUOut_M is still computed.
